// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - IF/MEM requester and memory command bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch requester
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_ready;

    // Data requester
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_ready;

    // Memory command / response
    logic                  m_req;
    logic                  m_we;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_be;
    logic [DATA_W-1:0]     m_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ready,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_rdata, d_ready,
        output m_req, m_we, m_addr, m_wdata, m_be,
        input  m_rdata
    );

    // Requesters and memory side
    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ready,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_rdata, d_ready,
        input  m_req, m_we, m_addr, m_wdata, m_be,
        output m_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/MEM arbiter for a fixed-latency single-port unified memory
module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 2,
    parameter int IF_STARVE = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(IF_STARVE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    state_t               state;
    state_t               state_next;
    owner_t               owner;
    logic                 grant_d;
    logic                 grant_i;
    logic                 if_starved;
    logic [STV_W-1:0]     starve_cnt;
    logic [LAT_W-1:0]     lat_cnt;

    logic                 cmd_we;
    logic [ADDR_W-1:0]    cmd_addr;
    logic [DATA_W-1:0]    cmd_wdata;
    logic [BE_W-1:0]      cmd_be;
    logic [DATA_W-1:0]    if_rdata_q;
    logic [DATA_W-1:0]    d_rdata_q;

    assign if_starved = (starve_cnt >= STV_W'(IF_STARVE));

    // Next-state and grant decode; data wins unless fetch has lost too often
    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.d_req && !(bus.if_req && if_starved)) begin
                    grant_d    = 1'b1;
                    state_next = S_ISSUE;
                end else if (bus.if_req) begin
                    grant_i    = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (lat_cnt == '0) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Latch the winner's command; fetches never write, and m_wdata keeps its old value on a fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= OWN_I;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_be    <= '0;
        end else if (grant_d) begin
            owner     <= OWN_D;
            cmd_we    <= bus.d_we;
            cmd_addr  <= bus.d_addr;
            cmd_wdata <= bus.d_wdata;
            cmd_be    <= bus.d_be;
        end else if (grant_i) begin
            owner     <= OWN_I;
            cmd_we    <= 1'b0;
            cmd_addr  <= bus.if_addr;
            cmd_be    <= '0;
        end
    end

    // Count data wins that left a fetch waiting; a fetch grant clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && bus.if_req && !if_starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Memory latency countdown: reaches zero in the cycle m_rdata is valid
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt <= '0;
        end else if (state == S_ISSUE) begin
            lat_cnt <= LAT_W'(MEM_LAT - 1);
        end else if (state == S_WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    // Capture read data for the owner; stores leave d_rdata untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (state == S_WAIT && lat_cnt == '0) begin
            if (owner == OWN_I)  if_rdata_q <= bus.m_rdata;
            else if (!cmd_we)    d_rdata_q  <= bus.m_rdata;
        end
    end

    assign bus.m_req    = (state == S_ISSUE);
    assign bus.m_we     = cmd_we;
    assign bus.m_addr   = cmd_addr;
    assign bus.m_wdata  = cmd_wdata;
    assign bus.m_be     = cmd_be;
    assign bus.if_ready = (state == S_DONE) && (owner == OWN_I);
    assign bus.d_ready  = (state == S_DONE) && (owner == OWN_D);
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int LAT = 2;
    localparam int STV = 4;

    logic clk = 1'b0;
    logic reset;
    logic reset_x;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .IF_STARVE(STV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

    // Environment memory: responds MEM_LAT cycles after each m_req, garbage otherwise
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] resp    [int];
    logic [31:0] ref_mem [logic [31:0]];

    initial begin
        logic [31:0] cur;
        forever begin
            @(negedge clk);
            if (bus.m_req === 1'b1) begin
                cur = env_mem.exists(bus.m_addr) ? env_mem[bus.m_addr] : dflt(bus.m_addr);
                resp[cyc + LAT] = cur;
                if (bus.m_we) env_mem[bus.m_addr] = merge(cur, bus.m_wdata, bus.m_be);
            end
        end
    end

    initial begin
        bus.m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp.exists(cyc)) begin
                bus.m_rdata = resp[cyc];
                resp.delete(cyc);
            end else begin
                bus.m_rdata = 32'hBAD0_0000 | (cyc & 32'hFFFF);
            end
        end
    end

    // Transaction-level reference: each grant occupies MEM_LAT+3 cycles starting at the grant cycle
    initial begin
        int n, iss_c, rdy_c, free_at, starve;
        bit armed, p_d, p_we;
        logic [31:0] p_addr, p_wdata, p_data, cur;
        logic [3:0]  p_be;
        logic [31:0] e_addr, e_wdata, e_if, e_d;
        logic [3:0]  e_be;
        logic        e_we;
        armed = 0; iss_c = -1; rdy_c = -1; free_at = 0; starve = 0;
        p_d = 0; p_we = 0; p_addr = 0; p_wdata = 0; p_data = 0; p_be = 0;
        e_addr = 0; e_wdata = 0; e_if = 0; e_d = 0; e_be = 0; e_we = 0;
        forever begin
            @(negedge clk);
            n = cyc;
            if (armed) begin
                if (n == iss_c) begin
                    e_addr = p_addr; e_we = p_we; e_be = p_be;
                    if (p_d) e_wdata = p_wdata;
                    cur = ref_mem.exists(p_addr) ? ref_mem[p_addr] : dflt(p_addr);
                    p_data = cur;
                    if (p_we) ref_mem[p_addr] = merge(cur, p_wdata, p_be);
                end
                if (n == rdy_c) begin
                    if (!p_d)      e_if = p_data;
                    else if (!p_we) e_d = p_data;
                end
                chk("m_req",    32'(bus.m_req),    32'(n == iss_c));
                chk("if_ready", 32'(bus.if_ready), 32'(n == rdy_c && !p_d));
                chk("d_ready",  32'(bus.d_ready),  32'(n == rdy_c && p_d));
                chk("m_we",     32'(bus.m_we),     32'(e_we));
                chk("m_addr",   bus.m_addr,  e_addr);
                chk("m_wdata",  bus.m_wdata, e_wdata);
                chk("m_be",     32'(bus.m_be), 32'(e_be));
                chk("if_rdata", bus.if_rdata, e_if);
                chk("d_rdata",  bus.d_rdata,  e_d);
            end
            if (reset) begin
                armed = 1; iss_c = -1; rdy_c = -1; free_at = n + 1; starve = 0;
                e_addr = 0; e_wdata = 0; e_if = 0; e_d = 0; e_be = 0; e_we = 0;
            end else if (armed && n >= free_at) begin
                if (bus.d_req && !(bus.if_req && starve >= STV)) begin
                    p_d = 1; p_we = bus.d_we; p_addr = bus.d_addr; p_wdata = bus.d_wdata; p_be = bus.d_be;
                    if (bus.if_req && starve < STV) starve++;
                    iss_c = n + 1; rdy_c = n + 2 + LAT; free_at = n + 3 + LAT;
                end else if (bus.if_req) begin
                    p_d = 0; p_we = 0; p_addr = bus.if_addr; p_be = 0;
                    starve = 0;
                    iss_c = n + 1; rdy_c = n + 2 + LAT; free_at = n + 3 + LAT;
                end
            end
        end
    end

    // Single fetch on MEM_LAT=1 and MEM_LAT=5 builds
    initial begin
        reset_x = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_x = 1'b0;
    end

    for (genvar g = 0; g < 2; g++) begin : g_lat
        localparam int L = (g == 0) ? 1 : 5;
        mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();
        mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .IF_STARVE(STV)) u (
            .clk   (clk),
            .reset (reset_x),
            .bus   (b.slave)
        );

        initial begin
            b.m_rdata = '0;
            forever begin
                @(posedge clk);
                #1 b.m_rdata = {16'hC0DE, cyc[15:0]};
            end
        end

        initial begin
            int t, rdy, nreq, nd;
            logic [31:0] got;
            b.if_req = 0; b.if_addr = 0; b.d_req = 0; b.d_we = 0;
            b.d_addr = 0; b.d_wdata = 0; b.d_be = 0;
            rdy = -1; nreq = 0; nd = 0; got = 0;
            repeat (6) @(posedge clk);
            #1;
            b.if_req = 1; b.if_addr = 32'h40; t = cyc;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (b.m_req) nreq++;
                if (b.d_ready) nd++;
                if (b.if_ready && rdy < 0) begin rdy = cyc - t; got = b.if_rdata; end
                @(posedge clk);
                #1;
                if (rdy >= 0) b.if_req = 0;
            end
            chk($sformatf("lat%0d_ready_cycle", L), rdy, L + 2);
            chk($sformatf("lat%0d_mreq_count", L), nreq, 1);
            chk($sformatf("lat%0d_d_ready_count", L), nd, 0);
            chk($sformatf("lat%0d_rdata", L), got, {16'hC0DE, 16'(t + 1 + L)});
        end
    end

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dbe;
        logic        exp_d;
        logic [31:0] exp_maddr;
        logic        exp_mwe;
        logic [3:0]  exp_mbe;
        int          exp_lat;
        logic [31:0] exp_rdata;
        int          exp_lat2;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int t, fm, r1, r2, nr, ng;
        bit di, dd, r1d, saw_i, saw_d;
        logic [31:0] ma, mwd, r1v;
        logic mwe;
        logic [3:0] mbe;
        int owners [10];

        vecs[0] = '{1'b1, 32'h100,  1'b0, 1'b0, 32'h0,    32'h0,        4'h0,    1'b0, 32'h100,  1'b0, 4'h0,    LAT + 2, 32'h00500093, -1};
        vecs[1] = '{1'b1, 32'h104,  1'b1, 1'b0, 32'h2000, 32'h0,        4'hF,    1'b1, 32'h2000, 1'b0, 4'hF,    LAT + 2, 32'h11223344, 2 * LAT + 5};
        vecs[2] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h3004, 32'hDEADBEEF, 4'b0011, 1'b1, 32'h3004, 1'b1, 4'b0011, LAT + 2, 32'h11223344, -1};
        vecs[3] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h3004, 32'h0,        4'hF,    1'b1, 32'h3004, 1'b0, 4'hF,    LAT + 2, 32'hAABBBEEF, -1};
        vecs[4] = '{1'b1, 32'h3004, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0,    1'b0, 32'h3004, 1'b0, 4'h0,    LAT + 2, 32'hAABBBEEF, -1};

        env_mem[32'h100]  = 32'h00500093; ref_mem[32'h100]  = 32'h00500093;
        env_mem[32'h2000] = 32'h11223344; ref_mem[32'h2000] = 32'h11223344;
        env_mem[32'h3004] = 32'hAABBCCDD; ref_mem[32'h3004] = 32'hAABBCCDD;

        reset = 1;
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.d_be = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        @(negedge clk);
        chk("rst_m_req",    32'(bus.m_req), 0);
        chk("rst_m_we",     32'(bus.m_we), 0);
        chk("rst_m_addr",   bus.m_addr, 0);
        chk("rst_if_ready", 32'(bus.if_ready), 0);
        chk("rst_d_ready",  32'(bus.d_ready), 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_d_rdata",  bus.d_rdata, 0);
        @(posedge clk);
        #1;

        // Table vectors, each started from IDLE
        foreach (vecs[i]) begin
            bus.if_req = vecs[i].ireq; bus.if_addr = vecs[i].iaddr;
            bus.d_req = vecs[i].dreq; bus.d_we = vecs[i].dwe; bus.d_addr = vecs[i].daddr;
            bus.d_wdata = vecs[i].dwdata; bus.d_be = vecs[i].dbe;
            t = cyc; fm = -1; r1 = -1; r2 = -1;
            ma = 0; mwd = 0; mwe = 0; mbe = 0; r1d = 0; r1v = 0;
            for (int k = 0; k < 40 && (bus.if_req || bus.d_req); k++) begin
                @(negedge clk);
                if (bus.m_req && fm < 0) begin
                    fm = cyc - t; ma = bus.m_addr; mwe = bus.m_we; mbe = bus.m_be; mwd = bus.m_wdata;
                end
                if (bus.if_ready || bus.d_ready) begin
                    if (r1 < 0) begin
                        r1 = cyc - t; r1d = bus.d_ready;
                        r1v = bus.d_ready ? bus.d_rdata : bus.if_rdata;
                    end else if (r2 < 0) begin
                        r2 = cyc - t;
                    end
                end
                di = bus.if_ready; dd = bus.d_ready;
                @(posedge clk);
                #1;
                if (di) bus.if_req = 0;
                if (dd) bus.d_req = 0;
            end
            chk($sformatf("v%0d_timeout", i), 32'(bus.if_req | bus.d_req), 0);
            bus.if_req = 0; bus.d_req = 0;
            chk($sformatf("v%0d_mreq_cycle", i), fm, 1);
            chk($sformatf("v%0d_m_addr", i), ma, vecs[i].exp_maddr);
            chk($sformatf("v%0d_m_we", i), 32'(mwe), 32'(vecs[i].exp_mwe));
            chk($sformatf("v%0d_m_be", i), 32'(mbe), 32'(vecs[i].exp_mbe));
            if (vecs[i].exp_mwe) chk($sformatf("v%0d_m_wdata", i), mwd, vecs[i].dwdata);
            chk($sformatf("v%0d_ready_cycle", i), r1, vecs[i].exp_lat);
            chk($sformatf("v%0d_ready_is_d", i), 32'(r1d), 32'(vecs[i].exp_d));
            chk($sformatf("v%0d_rdata", i), r1v, vecs[i].exp_rdata);
            chk($sformatf("v%0d_second_ready", i), r2, vecs[i].exp_lat2);
            repeat (2) @(posedge clk);
            #1;
        end

        // Reset while waiting for memory: the access is dropped without a ready
        bus.if_req = 1; bus.if_addr = 32'h100; t = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1; bus.if_req = 0;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("rw_m_req",    32'(bus.m_req), 0);
        chk("rw_m_we",     32'(bus.m_we), 0);
        chk("rw_m_addr",   bus.m_addr, 0);
        chk("rw_m_wdata",  bus.m_wdata, 0);
        chk("rw_m_be",     32'(bus.m_be), 0);
        chk("rw_if_ready", 32'(bus.if_ready), 0);
        chk("rw_d_ready",  32'(bus.d_ready), 0);
        chk("rw_if_rdata", bus.if_rdata, 0);
        chk("rw_d_rdata",  bus.d_rdata, 0);
        nr = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.if_ready || bus.d_ready) nr++;
        end
        chk("rw_no_ready", nr, 0);
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_addr = 32'h104; t = cyc; r1 = -1;
        for (int k = 0; k < 20 && r1 < 0; k++) begin
            @(negedge clk);
            if (bus.if_ready) r1 = cyc - t;
            @(posedge clk); #1;
        end
        bus.if_req = 0;
        chk("rw_refetch_ready", r1, LAT + 2);
        repeat (2) @(posedge clk);
        #1;

        // Starvation guard: with both held, fetch wins every fifth arbitration
        bus.if_req = 1; bus.if_addr = 32'h4000;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h8000; bus.d_be = 4'hF;
        ng = 0;
        for (int k = 0; k < 200 && ng < 10; k++) begin
            @(negedge clk);
            if (bus.m_req) begin
                owners[ng] = (bus.m_addr == 32'h8000) ? 1 : 0;
                ng++;
            end
            @(posedge clk); #1;
        end
        chk("starve_grants_seen", ng, 10);
        for (int k = 0; k < 10; k++)
            chk($sformatf("starve_grant%0d_is_d", k), (k < ng) ? owners[k] : -1, (k % 5 == 4) ? 0 : 1);
        bus.if_req = 0; bus.d_req = 0;
        repeat (LAT + 6) @(posedge clk);
        #1;

        // Randomized traffic against the reference model
        saw_i = 0; saw_d = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!bus.if_req || saw_i) begin
                bus.if_req = ($urandom_range(0, 3) != 0);
                bus.if_addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
            end
            if (!bus.d_req || saw_d) begin
                bus.d_req = ($urandom_range(0, 3) != 0);
                bus.d_we = 1'($urandom_range(0, 1));
                bus.d_addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
                bus.d_wdata = $urandom;
                bus.d_be = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            saw_i = bus.if_ready; saw_d = bus.d_ready;
            @(posedge clk); #1;
        end
        bus.if_req = 0; bus.d_req = 0;
        repeat (LAT + 6) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
